// File: rtl/pipe_stage_ctrl.sv
// rtl/pipe_stage_ctrl.sv - pipeline stall/flush sequencer with memory-wait watchdog
// Optional live stall counter is built when STALL_CNT_EN is defined.
module pipe_stage_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_use_hazard,
  input  logic             br_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic [4:0]       ce,
  output logic [1:0]       flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1) + 1;

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            mem_timeout_q, mem_timeout_d;
  logic [4:0]      ce_adv;
  logic [1:0]      flush_adv;

  // Advance decision used by RUN and by the MEM_WAIT release cycle.
  always_comb begin
    ce_adv    = 5'b11111;
    flush_adv = 2'b00;
    if (br_taken) begin
      flush_adv = 2'b11;
    end else if (ld_use_hazard) begin
      ce_adv    = 5'b11100;
      flush_adv = 2'b10;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    ce            = 5'b00000;
    flush         = 2'b00;
    case (state_q)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WW'(1);
        end else begin
          ce    = ce_adv;
          flush = flush_adv;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          ce         = ce_adv;
          flush      = flush_adv;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          if ((MEM_TIMEOUT != 0) && (wait_cnt_q == WW'(MEM_TIMEOUT))) begin
            state_d       = ERR;
            mem_timeout_d = 1'b1;
          end
          // Saturate so a disabled watchdog cannot wrap the count.
          if (wait_cnt_q != '1) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
          end
        end
      end
      ERR: begin
        mem_timeout_d = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    if (!rst_n) begin
      ce    = 5'b00000;
      flush = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!ce[0] && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// tb/tb_pipe_stage_ctrl.sv - scoreboard bench for pipe_stage_ctrl
module tb_pipe_stage_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ld_use_hazard = 1'b0;
  logic          br_taken = 1'b0;
  logic          dmem_req = 1'b0;
  logic          dmem_ready = 1'b0;
  logic [4:0]    ce;
  logic [1:0]    flush;
  logic          mem_timeout;
  logic [CW-1:0] stall_cnt;

  pipe_stage_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ld_use_hazard(ld_use_hazard), .br_taken(br_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .ce(ce), .flush(flush),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]    ce;
    logic [1:0]    fl;
    logic          to;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  // Reference model: waiting / errored flags, count of MEM_WAIT cycles, stall total.
  bit   m_wait, m_err;
  int   m_waited, m_stalls;

  task automatic step(input bit r, input bit ld, input bit br, input bit rq, input bit rd);
    exp_t e;
    bit   stall;
    @(posedge clk);
    #1;
    rst_n = r; ld_use_hazard = ld; br_taken = br; dmem_req = rq; dmem_ready = rd;
    if (!r) begin
      m_wait = 0; m_err = 0; m_waited = 0; m_stalls = 0;
      e.ce = 5'b00000; e.fl = 2'b00; e.to = 1'b0; e.cnt = '0;
    end else begin
      e.to = m_err;
`ifdef STALL_CNT_EN
      e.cnt = CW'(m_stalls);
`else
      e.cnt = '0;
`endif
      stall = m_err || (!rd && (m_wait || rq));
      if (stall) begin
        e.ce = 5'b00000; e.fl = 2'b00;
      end else if (br) begin
        e.ce = 5'b11111; e.fl = 2'b11;
      end else if (ld) begin
        e.ce = 5'b11100; e.fl = 2'b10;
      end else begin
        e.ce = 5'b11111; e.fl = 2'b00;
      end
      if (stall && m_stalls < (1 << CW) - 1) m_stalls++;
      if (!m_err) begin
        if (m_wait) begin
          if (rd) begin
            m_wait = 0; m_waited = 0;
          end else begin
            m_waited++;
            if (m_waited == TO) m_err = 1;
          end
        end else if (rq && !rd) begin
          m_wait = 1; m_waited = 0;
        end
      end
    end
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ce", 32'(ce), 32'(e.ce));
        chk("flush", 32'(flush), 32'(e.fl));
        chk("mem_timeout", 32'(mem_timeout), 32'(e.to));
        chk("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin : stim
    bit long_stall;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (3) step(1, 0, 1, 1, 0);
    step(1, 0, 1, 1, 1);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 1);
    repeat (9) step(1, 0, 0, 1, 0);
    step(1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (20) step(1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    long_stall = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) long_stall = ~long_stall;
      step(($urandom_range(0, 59) != 0), $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 2) == 0, long_stall ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) != 0));
    end
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
